// File: rtl/mem_read_arbiter.sv
// Shares one memory read port between instruction-fetch and data read channels.
// Optional round-robin arbitration with MEM_ARB_ROUND_ROBIN_EN; the default is fixed priority (D over I).
module mem_read_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_raddr_valid,
  output logic                                 i_raddr_ready,
  input  logic [ADDR_WIDTH-1:0]                i_raddr,
  output logic                                 i_rdata_valid,
  input  logic                                 i_rdata_ready,
  output logic [DATA_WIDTH-1:0]                i_rdata,
  input  logic                                 d_raddr_valid,
  output logic                                 d_raddr_ready,
  input  logic [ADDR_WIDTH-1:0]                d_raddr,
  output logic                                 d_rdata_valid,
  input  logic                                 d_rdata_ready,
  output logic [DATA_WIDTH-1:0]                d_rdata,
  output logic                                 m_raddr_valid,
  input  logic                                 m_raddr_ready,
  output logic [ADDR_WIDTH-1:0]                m_raddr,
  input  logic                                 m_rdata_valid,
  output logic                                 m_rdata_ready,
  input  logic [DATA_WIDTH-1:0]                m_rdata,
  output logic [$clog2(MAX_OUTSTANDING):0]     outstanding
);

  // Handshake: a transfer happens on a rising edge where valid && ready; the
  // source keeps valid and payload stable until that edge.

  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

  state_t                     state, state_nxt;
  logic                       lock_id, lock_id_nxt;
  logic                       sel, pick;
  logic                       sel_valid;
  logic [ADDR_WIDTH-1:0]      sel_addr;
  logic [CW-1:0]              count;
  logic [PW-1:0]              wr_ptr, rd_ptr;
  logic [MAX_OUTSTANDING-1:0] tag_mem;
  logic                       full, empty, head, push, pop;

  assign full  = (count == CW'(MAX_OUTSTANDING));
  assign empty = (count == '0);
  assign head  = tag_mem[rd_ptr];

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic rr_last;

  always_comb begin
    if (i_raddr_valid && d_raddr_valid) pick = ~rr_last;
    else                                pick = d_raddr_valid;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      rr_last <= 1'b1;
    else if (push) rr_last <= sel;
  end
`else
  assign pick = d_raddr_valid;
`endif

  assign sel       = (state == LOCKED) ? lock_id : pick;
  assign sel_valid = sel ? d_raddr_valid : i_raddr_valid;
  assign sel_addr  = sel ? d_raddr : i_raddr;

  // Every output is forced low while reset is held, whatever the requesters drive.
  assign m_raddr_valid = rst && sel_valid && !full;
  assign m_raddr       = (rst && sel_valid) ? sel_addr : '0;
  assign i_raddr_ready = rst && !sel && m_raddr_ready && !full;
  assign d_raddr_ready = rst &&  sel && m_raddr_ready && !full;

  assign m_rdata_ready = rst && !empty && (head ? d_rdata_ready : i_rdata_ready);
  assign i_rdata_valid = rst && m_rdata_valid && !empty && !head;
  assign d_rdata_valid = rst && m_rdata_valid && !empty &&  head;
  assign i_rdata       = rst ? m_rdata : '0;
  assign d_rdata       = rst ? m_rdata : '0;

  assign push = m_raddr_valid && m_raddr_ready;
  assign pop  = m_rdata_valid && m_rdata_ready;

  assign outstanding = count;

  // Address-phase FSM: lock the current owner while memory stalls its address.
  always_comb begin
    state_nxt   = state;
    lock_id_nxt = lock_id;
    case (state)
      UNLOCKED: begin
        if (m_raddr_valid && !m_raddr_ready) begin
          state_nxt   = LOCKED;
          lock_id_nxt = sel;
        end
      end
      LOCKED: begin
        if (push) state_nxt = UNLOCKED;
      end
      default: state_nxt = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= UNLOCKED;
      lock_id <= 1'b0;
    end else begin
      state   <= state_nxt;
      lock_id <= lock_id_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Tag storage needs no reset: entries are only read once count covers them.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= sel;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst && m_rdata_valid && empty)
      $error("mem_read_arbiter: m_rdata_valid with no outstanding read");
  end
`endif

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed self-checking bench for mem_read_arbiter (MAX_OUTSTANDING = 4).
// Expectations follow MEM_ARB_ROUND_ROBIN_EN if the bench is built with it.
module tb_mem_read_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_raddr_valid, i_raddr_ready;
  logic [31:0] i_raddr;
  logic        i_rdata_valid, i_rdata_ready;
  logic [31:0] i_rdata;
  logic        d_raddr_valid, d_raddr_ready;
  logic [31:0] d_raddr;
  logic        d_rdata_valid, d_rdata_ready;
  logic [31:0] d_rdata;
  logic        m_raddr_valid, m_raddr_ready;
  logic [31:0] m_raddr;
  logic        m_rdata_valid, m_rdata_ready;
  logic [31:0] m_rdata;
  logic [2:0]  outstanding;

  int n_cmp = 0;
  int n_err = 0;

  mem_read_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .rst(rst),
    .i_raddr_valid(i_raddr_valid), .i_raddr_ready(i_raddr_ready), .i_raddr(i_raddr),
    .i_rdata_valid(i_rdata_valid), .i_rdata_ready(i_rdata_ready), .i_rdata(i_rdata),
    .d_raddr_valid(d_raddr_valid), .d_raddr_ready(d_raddr_ready), .d_raddr(d_raddr),
    .d_rdata_valid(d_rdata_valid), .d_rdata_ready(d_rdata_ready), .d_rdata(d_rdata),
    .m_raddr_valid(m_raddr_valid), .m_raddr_ready(m_raddr_ready), .m_raddr(m_raddr),
    .m_rdata_valid(m_rdata_valid), .m_rdata_ready(m_rdata_ready), .m_rdata(m_rdata),
    .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  // Inputs change just after the falling edge; outputs are sampled 1ns later.
  task automatic clear_inputs();
    i_raddr_valid = 0; i_raddr = '0; i_rdata_ready = 0;
    d_raddr_valid = 0; d_raddr = '0; d_rdata_ready = 0;
    m_raddr_ready = 0; m_rdata_valid = 0; m_rdata = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    clear_inputs();
    rst = 0;
    repeat (2) @(negedge clk);
    rst = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 0;
    i_raddr_valid = 1; i_raddr = 32'h44; d_raddr_valid = 1; d_raddr = 32'h88;
    m_raddr_ready = 1; i_rdata_ready = 1; m_rdata_valid = 1; m_rdata = 32'h1234;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (m_raddr_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_raddr_valid got %b want 0", m_raddr_valid); end
    n_cmp++; if (m_raddr !== 32'h0) begin n_err++; $display("FAIL reset_m_raddr got %h want 0", m_raddr); end
    n_cmp++; if ({i_raddr_ready, d_raddr_ready, m_rdata_ready} !== 3'b000) begin n_err++; $display("FAIL reset_readies got %b want 000", {i_raddr_ready, d_raddr_ready, m_rdata_ready}); end
    n_cmp++; if ({i_rdata_valid, d_rdata_valid, i_rdata, d_rdata} !== 66'h0) begin n_err++; $display("FAIL reset_rdata got %b %b %h %h want zeros", i_rdata_valid, d_rdata_valid, i_rdata, d_rdata); end
    n_cmp++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL reset_outstanding got %0d want 0", outstanding); end
    clear_inputs();
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    i_raddr_valid = 1; i_raddr = 32'h100; m_raddr_ready = 1;
    #1;
    n_cmp++; if ({m_raddr_valid, i_raddr_ready, d_raddr_ready} !== 3'b110) begin n_err++; $display("FAIL single_grant got %b want 110", {m_raddr_valid, i_raddr_ready, d_raddr_ready}); end
    n_cmp++; if (m_raddr !== 32'h100) begin n_err++; $display("FAIL single_m_raddr got %h want 00000100", m_raddr); end
    @(negedge clk);
    i_raddr_valid = 0; m_raddr_ready = 0;
    i_rdata_ready = 1; m_rdata_valid = 1; m_rdata = 32'hDEADBEEF;
    #1;
    n_cmp++; if (outstanding !== 3'd1) begin n_err++; $display("FAIL single_outstanding_1 got %0d want 1", outstanding); end
    n_cmp++; if ({i_rdata_valid, d_rdata_valid, m_rdata_ready} !== 3'b101) begin n_err++; $display("FAIL single_resp got %b want 101", {i_rdata_valid, d_rdata_valid, m_rdata_ready}); end
    n_cmp++; if (i_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_i_rdata got %h want deadbeef", i_rdata); end
    @(negedge clk);
    m_rdata_valid = 0; i_rdata_ready = 0;
    #1;
    n_cmp++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL single_outstanding_0 got %0d want 0", outstanding); end
  endtask

  task automatic test_arbitration();
    logic [31:0] exp_addr [4];
    logic        exp_d [4];
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_addr = '{32'h10, 32'h2000, 32'h10, 32'h2000};
    exp_d    = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_addr = '{32'h2000, 32'h2000, 32'h2000, 32'h2000};
    exp_d    = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      i_raddr_valid = 1; i_raddr = 32'h10; d_raddr_valid = 1; d_raddr = 32'h2000; m_raddr_ready = 1;
      #1;
      n_cmp++; if (m_raddr !== exp_addr[k]) begin n_err++; $display("FAIL arb_addr[%0d] got %h want %h", k, m_raddr, exp_addr[k]); end
      n_cmp++; if ({i_raddr_ready, d_raddr_ready} !== {~exp_d[k], exp_d[k]}) begin n_err++; $display("FAIL arb_ready[%0d] got %b want %b", k, {i_raddr_ready, d_raddr_ready}, {~exp_d[k], exp_d[k]}); end
    end
    @(negedge clk);
    clear_inputs();
    #1;
    n_cmp++; if (outstanding !== 3'd4) begin n_err++; $display("FAIL arb_outstanding got %0d want 4", outstanding); end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      i_rdata_ready = 1; d_rdata_ready = 1; m_rdata_valid = 1; m_rdata = 32'hA000 + k;
      #1;
      n_cmp++; if ({i_rdata_valid, d_rdata_valid} !== {~exp_d[k], exp_d[k]}) begin n_err++; $display("FAIL arb_route[%0d] got %b want %b", k, {i_rdata_valid, d_rdata_valid}, {~exp_d[k], exp_d[k]}); end
    end
    @(negedge clk);
    clear_inputs();
    #1;
    n_cmp++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL arb_drained got %0d want 0", outstanding); end
  endtask

  task automatic test_lock();
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      i_raddr_valid = 1; i_raddr = 32'h40; m_raddr_ready = 0;
      if (k > 0) begin d_raddr_valid = 1; d_raddr = 32'h2000; end
      #1;
      n_cmp++; if (m_raddr !== 32'h40) begin n_err++; $display("FAIL lock_addr[%0d] got %h want 00000040", k, m_raddr); end
      n_cmp++; if ({i_raddr_ready, d_raddr_ready} !== 2'b00) begin n_err++; $display("FAIL lock_ready[%0d] got %b want 00", k, {i_raddr_ready, d_raddr_ready}); end
    end
    @(negedge clk);
    m_raddr_ready = 1;
    #1;
    n_cmp++; if ({m_raddr, i_raddr_ready, d_raddr_ready} !== {32'h40, 2'b10}) begin n_err++; $display("FAIL lock_release got %h %b want 00000040 10", m_raddr, {i_raddr_ready, d_raddr_ready}); end
    @(negedge clk);
    i_raddr_valid = 0;
    #1;
    n_cmp++; if ({m_raddr, i_raddr_ready, d_raddr_ready} !== {32'h2000, 2'b01}) begin n_err++; $display("FAIL lock_d_after got %h %b want 00002000 01", m_raddr, {i_raddr_ready, d_raddr_ready}); end
    @(negedge clk);
    clear_inputs();
    i_rdata_ready = 1; d_rdata_ready = 1; m_rdata_valid = 1;
    #1;
    n_cmp++; if ({i_rdata_valid, d_rdata_valid} !== 2'b10) begin n_err++; $display("FAIL lock_route_i got %b want 10", {i_rdata_valid, d_rdata_valid}); end
    @(negedge clk);
    #1;
    n_cmp++; if ({i_rdata_valid, d_rdata_valid} !== 2'b01) begin n_err++; $display("FAIL lock_route_d got %b want 01", {i_rdata_valid, d_rdata_valid}); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_full();
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      i_raddr_valid = 1; i_raddr = 32'h100 + 4 * k; m_raddr_ready = 1;
      #1;
      n_cmp++; if (i_raddr_ready !== 1'b1) begin n_err++; $display("FAIL full_accept[%0d] got %b want 1", k, i_raddr_ready); end
    end
    @(negedge clk);
    i_raddr = 32'h110;
    #1;
    n_cmp++; if ({i_raddr_ready, m_raddr_valid, outstanding} !== {2'b00, 3'd4}) begin n_err++; $display("FAIL full_block got %b %b %0d want 0 0 4", i_raddr_ready, m_raddr_valid, outstanding); end
    @(negedge clk);
    i_rdata_ready = 1; m_rdata_valid = 1; m_rdata = 32'h5555;
    #1;
    n_cmp++; if ({m_rdata_ready, i_raddr_ready} !== 2'b10) begin n_err++; $display("FAIL full_pop_cycle got %b want 10", {m_rdata_ready, i_raddr_ready}); end
    @(negedge clk);
    m_rdata_valid = 0;
    #1;
    n_cmp++; if ({i_raddr_ready, m_raddr, outstanding} !== {1'b1, 32'h110, 3'd3}) begin n_err++; $display("FAIL full_after_pop got %b %h %0d want 1 00000110 3", i_raddr_ready, m_raddr, outstanding); end
    @(negedge clk);
    i_raddr_valid = 0; m_raddr_ready = 0;
    m_rdata_valid = 1;
    #1;
    n_cmp++; if (outstanding !== 3'd4) begin n_err++; $display("FAIL full_refill got %0d want 4", outstanding); end
    repeat (4) @(negedge clk);
    clear_inputs();
    #1;
    n_cmp++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL full_drained got %0d want 0", outstanding); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    m_raddr_ready = 1;
    i_raddr_valid = 1; i_raddr = 32'h10;
    @(negedge clk);
    i_raddr_valid = 0; d_raddr_valid = 1; d_raddr = 32'h20;
    @(negedge clk);
    d_raddr_valid = 0; i_raddr_valid = 1; i_raddr = 32'h30;
    @(negedge clk);
    clear_inputs();
    i_rdata_ready = 1; m_rdata_valid = 1; m_rdata = 32'hAAAA0001;
    #1;
    n_cmp++; if ({i_rdata_valid, d_rdata_valid, m_rdata_ready, i_rdata} !== {3'b101, 32'hAAAA0001}) begin n_err++; $display("FAIL b2b_a got %b%b%b %h want 101 aaaa0001", i_rdata_valid, d_rdata_valid, m_rdata_ready, i_rdata); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      m_rdata = 32'hBBBB0002;
      #1;
      n_cmp++; if ({i_rdata_valid, d_rdata_valid, m_rdata_ready} !== 3'b010) begin n_err++; $display("FAIL b2b_b_stall[%0d] got %b want 010", k, {i_rdata_valid, d_rdata_valid, m_rdata_ready}); end
    end
    @(negedge clk);
    d_rdata_ready = 1;
    #1;
    n_cmp++; if ({d_rdata_valid, m_rdata_ready, d_rdata} !== {2'b11, 32'hBBBB0002}) begin n_err++; $display("FAIL b2b_b got %b%b %h want 11 bbbb0002", d_rdata_valid, m_rdata_ready, d_rdata); end
    @(negedge clk);
    m_rdata = 32'hCCCC0003;
    #1;
    n_cmp++; if ({i_rdata_valid, d_rdata_valid, i_rdata} !== {2'b10, 32'hCCCC0003}) begin n_err++; $display("FAIL b2b_c got %b%b %h want 10 cccc0003", i_rdata_valid, d_rdata_valid, i_rdata); end
    @(negedge clk);
    clear_inputs();
    #1;
    n_cmp++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL b2b_drained got %0d want 0", outstanding); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    i_raddr_valid = 1; i_raddr = 32'h200; m_raddr_ready = 1;
    repeat (2) @(negedge clk);
    clear_inputs();
    i_raddr_valid = 1; i_raddr = 32'h300; m_raddr_ready = 1;
    i_rdata_ready = 1; m_rdata_valid = 1; m_rdata = 32'h77;
    #1;
    n_cmp++; if (outstanding !== 3'd2) begin n_err++; $display("FAIL mid_before got %0d want 2", outstanding); end
    #1 rst = 0;
    #1;
    n_cmp++; if ({m_raddr_valid, i_raddr_ready, m_rdata_ready, i_rdata_valid, outstanding} !== 7'b0) begin n_err++; $display("FAIL mid_reset_outputs got %b%b%b%b %0d want 0000 0", m_raddr_valid, i_raddr_ready, m_rdata_ready, i_rdata_valid, outstanding); end
    n_cmp++; if ({m_raddr, i_rdata} !== 64'h0) begin n_err++; $display("FAIL mid_reset_buses got %h %h want 0 0", m_raddr, i_rdata); end
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    rst = 1;
    i_raddr_valid = 1; i_raddr = 32'h400; m_raddr_ready = 1;
    #1;
    n_cmp++; if ({m_raddr_valid, m_raddr} !== {1'b1, 32'h400}) begin n_err++; $display("FAIL mid_new_grant got %b %h want 1 00000400", m_raddr_valid, m_raddr); end
    @(negedge clk);
    clear_inputs();
    i_rdata_ready = 1; m_rdata_valid = 1; m_rdata = 32'h0BADF00D;
    #1;
    n_cmp++; if ({outstanding, i_rdata_valid, i_rdata} !== {3'd1, 1'b1, 32'h0BADF00D}) begin n_err++; $display("FAIL mid_new_resp got %0d %b %h want 1 1 0badf00d", outstanding, i_rdata_valid, i_rdata); end
    @(negedge clk);
    clear_inputs();
    #1;
    n_cmp++; if (outstanding !== 3'd0) begin n_err++; $display("FAIL mid_new_drained got %0d want 0", outstanding); end
  endtask

  initial begin
    clear_inputs();
    rst = 0;
    test_reset();
    test_single_read();
    test_arbitration();
    test_lock();
    test_full();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
